// File: rtl/fenced_wait_buffer.sv
`default_nettype none
// fenced_wait_buffer: wait buffer with operand wakeup, round-robin dispatch and a memory fence.
// Optional feature macro WAIT_BUFFER_BYPASS_EN: same-cycle writeback tags mark operands ready at insertion.
module fenced_wait_buffer #(
  parameter int NumTags         = 8,
  parameter int TagWidth        = $clog2(NumTags),
  parameter int PcWidth         = 32,
  parameter int WarpWidth       = 32,
  parameter int WaitBufferSize  = 4,
  parameter int RegIdxWidth     = 6,
  parameter int OperandsPerInst = 2,
  parameter int NumEuPorts      = 2,
  parameter int InstWidth       = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 fe_handshake_i,
  output logic                                 ib_space_available_o,
  input  logic                                 dec_stop_decoded_i,
  input  logic                                 dec_valid_i,
  output logic                                 wb_ready_o,
  input  logic [PcWidth-1:0]                   dec_pc_i,
  input  logic [WarpWidth-1:0]                 dec_act_mask_i,
  input  logic [TagWidth-1:0]                  dec_tag_i,
  input  logic [RegIdxWidth-1:0]               dec_dst_reg_i,
  input  logic [InstWidth-1:0]                 dec_inst_i,
  input  logic                                 dec_is_mem_i,
  input  logic                                 dec_is_fence_i,
  input  logic [OperandsPerInst-1:0]           dec_operands_required_i,
  input  logic [OperandsPerInst-1:0]           dec_operands_ready_i,
  input  logic [OperandsPerInst*TagWidth-1:0]  dec_operand_tags_i,
  input  logic [OperandsPerInst*RegIdxWidth-1:0] dec_operands_i,
  output logic                                 disp_valid_o,
  input  logic                                 opc_ready_i,
  output logic [TagWidth-1:0]                  disp_tag_o,
  output logic [PcWidth-1:0]                   disp_pc_o,
  output logic [WarpWidth-1:0]                 disp_act_mask_o,
  output logic [InstWidth-1:0]                 disp_inst_o,
  output logic [RegIdxWidth-1:0]               disp_dst_o,
  output logic [OperandsPerInst-1:0]           disp_operands_required_o,
  output logic [OperandsPerInst*RegIdxWidth-1:0] disp_operands_o,
  output logic                                 disp_is_mem_o,
  input  logic [NumEuPorts-1:0]                eu_valid_i,
  input  logic [NumEuPorts*TagWidth-1:0]       eu_tag_i,
  input  logic                                 mem_retire_valid_i,
  input  logic [TagWidth-1:0]                  mem_retire_tag_i,
  output logic                                 fence_active_o
);
  localparam int CREDIT_W = $clog2(WaitBufferSize + 1);
  localparam int IDX_W    = $clog2(WaitBufferSize);
  localparam int SUM_W    = CREDIT_W + 2;

  logic [WaitBufferSize-1:0]            valid_q, is_mem_q, behind_fence_q, eligible;
  logic [TagWidth-1:0]                  tag_q      [WaitBufferSize];
  logic [PcWidth-1:0]                   pc_q       [WaitBufferSize];
  logic [WarpWidth-1:0]                 mask_q     [WaitBufferSize];
  logic [InstWidth-1:0]                 inst_q     [WaitBufferSize];
  logic [RegIdxWidth-1:0]               dst_q      [WaitBufferSize];
  logic [OperandsPerInst-1:0]           op_req_q   [WaitBufferSize];
  logic [OperandsPerInst-1:0]           op_rdy_q   [WaitBufferSize];
  logic [OperandsPerInst-1:0]           op_rdy_d   [WaitBufferSize];
  logic [OperandsPerInst*TagWidth-1:0]  op_tags_q  [WaitBufferSize];
  logic [OperandsPerInst*RegIdxWidth-1:0] ops_q    [WaitBufferSize];

  logic [IDX_W-1:0]    rr_q, grant, free_idx;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [SUM_W-1:0]    credit_sum;
  logic [NumTags-1:0]  mem_pending_q, mem_pending_d, fence_mask_q, fence_mask_d;
  logic [NumTags-1:0]  retire_vec, snapshot;
  logic [OperandsPerInst-1:0] ins_rdy;
  logic full, accept, fence_accept, insert, disp_hs, any_elig;
  int   idx;

  assign full           = &valid_q;
  assign fence_active_o = |fence_mask_q;
  assign wb_ready_o     = dec_is_fence_i ? !fence_active_o : !full;
  assign accept         = dec_valid_i && wb_ready_o;
  assign fence_accept   = accept && dec_is_fence_i;
  assign insert         = accept && !dec_is_fence_i;
  assign disp_valid_o   = any_elig;
  assign disp_hs        = any_elig && opc_ready_i;
  assign ib_space_available_o = (credits_q != '0);

  always_comb begin
    eligible = '0;
    for (int i = 0; i < WaitBufferSize; i++)
      eligible[i] = valid_q[i] && (&op_rdy_q[i]) && !(is_mem_q[i] && behind_fence_q[i]);
  end

  // Round-robin search starting at rr_q, wrapping past the last entry.
  always_comb begin
    grant    = '0;
    any_elig = 1'b0;
    idx      = 0;
    for (int k = 0; k < WaitBufferSize; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= WaitBufferSize) idx = idx - WaitBufferSize;
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        grant    = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = WaitBufferSize - 1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IDX_W'(i);
  end

  always_comb begin
    for (int i = 0; i < WaitBufferSize; i++) begin
      op_rdy_d[i] = op_rdy_q[i];
      for (int j = 0; j < OperandsPerInst; j++)
        for (int p = 0; p < NumEuPorts; p++)
          if (valid_q[i] && eu_valid_i[p] &&
              op_tags_q[i][j*TagWidth +: TagWidth] == eu_tag_i[p*TagWidth +: TagWidth])
            op_rdy_d[i][j] = 1'b1;
    end
  end

  always_comb begin
    ins_rdy = dec_operands_ready_i | ~dec_operands_required_i;
`ifdef WAIT_BUFFER_BYPASS_EN
    for (int j = 0; j < OperandsPerInst; j++)
      for (int p = 0; p < NumEuPorts; p++)
        if (eu_valid_i[p] &&
            dec_operand_tags_i[j*TagWidth +: TagWidth] == eu_tag_i[p*TagWidth +: TagWidth])
          ins_rdy[j] = 1'b1;
`else
    ins_rdy = ins_rdy;
`endif
  end

  // Retire clears after the snapshot so a same-cycle retire of a snapshot tag wins.
  always_comb begin
    retire_vec = '0;
    if (mem_retire_valid_i) retire_vec[mem_retire_tag_i] = 1'b1;
    snapshot = mem_pending_q;
    for (int i = 0; i < WaitBufferSize; i++)
      if (valid_q[i] && is_mem_q[i]) snapshot[tag_q[i]] = 1'b1;
    fence_mask_d  = (fence_accept ? snapshot : fence_mask_q) & ~retire_vec;
    mem_pending_d = mem_pending_q & ~retire_vec;
    if (disp_hs && is_mem_q[grant]) mem_pending_d[tag_q[grant]] = 1'b1;
  end

  always_comb begin
    credit_sum = SUM_W'(credits_q) + SUM_W'(disp_hs) + SUM_W'(dec_stop_decoded_i)
               + SUM_W'(fence_accept);
    if (fe_handshake_i && credit_sum != '0) credit_sum = credit_sum - SUM_W'(1);
    if (credit_sum > SUM_W'(WaitBufferSize)) credits_d = CREDIT_W'(WaitBufferSize);
    else                                     credits_d = credit_sum[CREDIT_W-1:0];
  end

  assign disp_tag_o               = tag_q[grant];
  assign disp_pc_o                = pc_q[grant];
  assign disp_act_mask_o          = mask_q[grant];
  assign disp_inst_o              = inst_q[grant];
  assign disp_dst_o               = dst_q[grant];
  assign disp_operands_required_o = op_req_q[grant];
  assign disp_operands_o          = ops_q[grant];
  assign disp_is_mem_o            = is_mem_q[grant];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q          <= '0;
      credits_q     <= CREDIT_W'(WaitBufferSize);
      mem_pending_q <= '0;
      fence_mask_q  <= '0;
    end else begin
      if (disp_hs) rr_q <= (int'(grant) == WaitBufferSize - 1) ? '0 : grant + IDX_W'(1);
      credits_q     <= credits_d;
      mem_pending_q <= mem_pending_d;
      fence_mask_q  <= fence_mask_d;
    end
  end

  // A slot freed by dispatch only becomes insertable next cycle since free_idx uses valid_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q        <= '0;
      is_mem_q       <= '0;
      behind_fence_q <= '0;
      for (int i = 0; i < WaitBufferSize; i++) begin
        tag_q[i]     <= '0;
        pc_q[i]      <= '0;
        mask_q[i]    <= '0;
        inst_q[i]    <= '0;
        dst_q[i]     <= '0;
        op_req_q[i]  <= '0;
        op_rdy_q[i]  <= '0;
        op_tags_q[i] <= '0;
        ops_q[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < WaitBufferSize; i++) op_rdy_q[i] <= op_rdy_d[i];
      if (disp_hs) valid_q[grant] <= 1'b0;
      if (fence_mask_d == '0) behind_fence_q <= '0;
      if (insert) begin
        valid_q[free_idx]   <= 1'b1;
        is_mem_q[free_idx]  <= dec_is_mem_i;
        tag_q[free_idx]     <= dec_tag_i;
        pc_q[free_idx]      <= dec_pc_i;
        mask_q[free_idx]    <= dec_act_mask_i;
        inst_q[free_idx]    <= dec_inst_i;
        dst_q[free_idx]     <= dec_dst_reg_i;
        op_req_q[free_idx]  <= dec_operands_required_i;
        op_rdy_q[free_idx]  <= ins_rdy;
        op_tags_q[free_idx] <= dec_operand_tags_i;
        ops_q[free_idx]     <= dec_operands_i;
        if (fence_mask_d != '0) behind_fence_q[free_idx] <= fence_active_o;
      end
    end
  end
endmodule
`default_nettype wire

// File: doc/fenced_wait_buffer.md
# fenced_wait_buffer

- Successor of the per-warp wait buffer in the compute-unit dispatcher.
- Holds decoded instructions until their operands have been written back, then dispatches ready ones round-robin to the operand collector.
- New over the previous generation:
  - parametrised count of execution-unit writeback ports;
  - a memory fence that blocks younger memory instructions until all older memory operations have retired;
  - a real valid/ready decoder handshake.

## Interface
- NumTags, 8: instruction tags in flight; TagWidth = $clog2(NumTags).
- PcWidth, 32: program counter width.
- WarpWidth, 32: threads per warp (active-mask width).
- WaitBufferSize, 4: entries (≥2).
- RegIdxWidth, 6: register index width.
- OperandsPerInst, 2: operands per instruction.
- NumEuPorts, 2: parallel writeback ports (≥1).
- clk_i  in  1  clock.
- Reset is asynchronous, active-high: `rst_i  in  1`.
- fe_handshake_i  in  1  fetcher took a credit.
- ib_space_available_o  out  1  credits > 0.
- dec_stop_decoded_i  in  1  stop decoded; returns a credit.
- dec_valid_i / wb_ready_o  in / out  1  decoder handshake.
- Decoder payload inputs:
  - dec_pc_i, dec_act_mask_i, dec_tag_i, dec_dst_reg_i, dec_inst_i (inst_t): instruction payload.
  - dec_is_mem_i  in  1  memory instruction.
  - dec_is_fence_i  in  1  fence (payload ignored, no slot used).
  - dec_operands_required_i / dec_operands_ready_i  in  OperandsPerInst  per-operand flags.
  - dec_operand_tags_i  in  OperandsPerInst×TagWidth  producer tags.
  - dec_operands_i  in  OperandsPerInst×RegIdxWidth  source registers.
- disp_valid_o / opc_ready_i  out / in  1  dispatch handshake.
- Dispatch payload outputs: disp_tag_o, disp_pc_o, disp_act_mask_o, disp_inst_o, disp_dst_o, disp_operands_required_o, disp_operands_o, disp_is_mem_o.
- eu_valid_i  in  NumEuPorts  writeback valid per port.
- eu_tag_i  in  NumEuPorts×TagWidth  writeback tags.
- mem_retire_valid_i / mem_retire_tag_i  in  1 / TagWidth  memory op fully complete.
- fence_active_o  out  1  fence snapshot non-empty.

## Operation
**Credit counter**
- Width $clog2(WaitBufferSize+1); reset value WaitBufferSize.
- −1 on fe_handshake_i.
- +1 for each of: dispatch handshake; stop decoded; fence accepted.
- Dispatch and a decoder event in the same cycle give +2; take and give in the same cycle net out.
- Never exceeds WaitBufferSize.

**Decoder acceptance**
- wb_ready_o = dec_is_fence_i ? !fence_active_o : !full.
- An accepted non-fence instruction is inserted at the lowest-index free entry.
- operands_ready = dec_operands_ready_i | ~dec_operands_required_i.
- Stored flags: is_mem, and behind_fence = fence_active_o.

**Wakeup**
- Any valid entry whose operand is not yet ready and whose tag equals eu_tag_i[p] with eu_valid_i[p] set marks that operand ready.
- All ports are compared every cycle.

**Dispatch eligibility**
- valid && &operands_ready && !(is_mem && behind_fence).

**Arbiter**
- Round-robin pointer rr_q, reset 0.
- Grants the first eligible entry at or after rr_q, with wrap-around.
- On handshake: entry is invalidated and rr_q ← grant+1 mod WaitBufferSize.
- disp_valid_o = any eligible. Payload is the granted entry's contents.

**Memory tracking**
- mem_pending_q[NumTags]: set on dispatch of an is_mem entry; cleared on mem_retire.

**Fence**
- On acceptance: fence_mask_q ← mem_pending_q | tags of valid is_mem entries.
- Bits are then cleared on mem_retire.
- A snapshot that is empty at acceptance leaves the fence inactive (no-op).
- Retire and snapshot in the same cycle on the same tag: retire wins.
- When fence_mask_d == 0, every behind_fence bit clears.
- A second fence stalls (wb_ready_o=0) while a fence is active.

## Timing
**Reset values**
- ib_space_available_o=1, disp_valid_o=0, fence_active_o=0.
- wb_ready_o=1; every payload output is 0.
- Entries, rr_q and masks are all 0.

**Latency**
- An inserted, fully-ready entry can dispatch the next cycle at the earliest.
- Wakeup at cycle t → dispatch at t+1 at the earliest.
- Last fence-tag retire at t → blocked memory entry can dispatch at t+1.

**Simultaneous events**
- Dispatch and insert in the same cycle: the freed slot is not reusable until t+1 (full is computed from registered valids).
- Wakeup and dispatch of the same entry in the same cycle: dispatch wins.

**Protocol**
- disp_valid_o may drop without a handshake; this is not an AXI-stable interface.
- Reset asserted mid-operation clears all entries and fence state asynchronously.

## Configuration
**WAIT_BUFFER_BYPASS_EN**
- Defined: on insertion, an operand whose tag matches any valid eu port in the same cycle is stored ready.
- Undefined: the decoder is responsible for reflecting same-cycle writebacks in dec_operands_ready_i, and the insertion cycle performs no tag compare.

## Test plan
- Ready-operand insert, opc_ready_i=1 → disp_valid_o=1 next cycle. Credit sequence 4→3 on fetch, back to 4 on dispatch.
- Four blocked inserts with eu tags 5,6 on both ports simultaneously →
  - wb_ready_o=0 while full;
  - the two woken entries dispatch in rr order 0,1;
  - rr_q=2.
- Fence timing:
  - Dispatch mem tag 3 (retire pending); fence; insert mem tag 4 ready.
  - Tag 4 is held and fence_active_o=1.
  - mem_retire tag 3 at t → tag 4 dispatches at t+1.
- Fence with no memory ops pending → fence_active_o stays 0 and the credit is returned.
- Second fence during an active fence → wb_ready_o=0 until the first fence clears.
- Insert with operand tag 7 while eu_tag_i[1]=7 is valid:
  - with WAIT_BUFFER_BYPASS_EN it dispatches next cycle;
  - without it, it stays pending.
